// File: rtl/array_feeder.sv
// Systolic array operand feeder: reads ROWS row FIFOs with a
// one-word-per-row diagonal skew, zero padding the skew triangle and stalls.
module array_feeder #(
    parameter int DW   = 32,
    parameter int ROWS = 4,
    parameter int K    = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic [ROWS-1:0]      fifo_empty,
    input  logic [ROWS*DW-1:0]   fifo_rd_data,
    output logic [ROWS-1:0]      fifo_rd_en,
    output logic [ROWS*DW-1:0]   a_data,
    output logic [ROWS-1:0]      a_valid,
    output logic                 busy,
    output logic                 done
);

    localparam int TW = $clog2(K + ROWS);
    localparam logic [TW-1:0] T_LAST = TW'(K + ROWS - 2);

    typedef enum logic [1:0] {
        IDLE,
        FEED,
        FLUSH,
        DONE
    } state_t;

    state_t          r_state;
    state_t          w_next;
    logic [TW-1:0]   r_t;
    logic [TW-1:0]   w_t_next;
    logic [ROWS-1:0] w_active;
    logic [ROWS-1:0] w_rd_en;
    logic            w_stall;
    logic [ROWS-1:0] r_valid;
    int              w_ti;

    // Row r owns issue slots r .. r+K-1, which produces the skew diagonal.
    always_comb begin
        w_ti     = 32'(r_t);
        w_active = '0;
        for (int r = 0; r < ROWS; r++) begin
            w_active[r] = (w_ti >= r) && (w_ti < r + K);
        end
    end

    // Next state, issue counter and read enables; one empty active row stalls all rows.
    always_comb begin
        w_next   = r_state;
        w_t_next = r_t;
        w_rd_en  = '0;
        busy     = 1'b0;
        done     = 1'b0;
        w_stall  = |(w_active & fifo_empty);
        unique case (r_state)
            IDLE: begin
                if (start) begin
                    w_next   = FEED;
                    w_t_next = '0;
                end
            end
            FEED: begin
                busy = 1'b1;
                if (!w_stall) begin
                    w_rd_en = w_active;
                    if (r_t == T_LAST) begin
                        w_next = FLUSH;
                    end else begin
                        w_t_next = r_t + TW'(1);
                    end
                end
            end
            FLUSH: begin
                busy   = 1'b1;
                w_next = DONE;
            end
            DONE: begin
                done   = 1'b1;
                w_next = IDLE;
            end
            default: begin
                w_next = IDLE;
            end
        endcase
    end

    // State and issue counter registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_t     <= '0;
        end else begin
            r_state <= w_next;
            r_t     <= w_t_next;
        end
    end

    // Valid follows the read enable by the FIFO's one-cycle read latency.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_valid <= '0;
        end else begin
            r_valid <= w_rd_en;
        end
    end

    assign fifo_rd_en = w_rd_en;
    assign a_valid    = r_valid;

    for (genvar g = 0; g < ROWS; g++) begin : g_row
        assign a_data[g*DW +: DW] = r_valid[g] ? fifo_rd_data[g*DW +: DW] : '0;
    end

endmodule

// File: tb/tb_array_feeder.sv
// Self-checking bench for array_feeder: FIFO model, scoreboard of expected
// words per row, table of per-cycle control expectations.
module tb_array_feeder;

    localparam int DW   = 32;
    localparam int ROWS = 4;
    localparam int K    = 8;

    logic                 clk;
    logic                 rst_n;
    logic                 start;
    logic [ROWS-1:0]      fifo_empty;
    logic [ROWS*DW-1:0]   fifo_rd_data;
    logic [ROWS-1:0]      fifo_rd_en;
    logic [ROWS*DW-1:0]   a_data;
    logic [ROWS-1:0]      a_valid;
    logic                 busy;
    logic                 done;

    logic                 start1;
    logic [0:0]           fifo_empty1;
    logic [DW-1:0]        fifo_rd_data1;
    logic [0:0]           fifo_rd_en1;
    logic [DW-1:0]        a_data1;
    logic [0:0]           a_valid1;
    logic                 busy1;
    logic                 done1;

    array_feeder #(.DW(DW), .ROWS(ROWS), .K(K)) dut (
        .clk(clk), .rst_n(rst_n), .start(start),
        .fifo_empty(fifo_empty), .fifo_rd_data(fifo_rd_data),
        .fifo_rd_en(fifo_rd_en), .a_data(a_data), .a_valid(a_valid),
        .busy(busy), .done(done)
    );

    array_feeder #(.DW(DW), .ROWS(1), .K(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .start(start1),
        .fifo_empty(fifo_empty1), .fifo_rd_data(fifo_rd_data1),
        .fifo_rd_en(fifo_rd_en1), .a_data(a_data1), .a_valid(a_valid1),
        .busy(busy1), .done(done1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    // Row FIFO model: words are addressed by a per-row read pointer.
    int            rptr [ROWS] = '{default: 0};
    int            avail[ROWS] = '{default: 0};
    logic [31:0]   rd_q [ROWS] = '{default: 32'hDEAD_BEEF};
    logic [ROWS-1:0] force_empty = '0;
    int            uflow = 0;
    logic [31:0]   sb[ROWS][$];
    logic [31:0]   rd_q1 = 32'h0000_0077;
    logic [31:0]   sb1[$];

    function automatic logic [31:0] word(input int r, input int p);
        return 32'hA000_0000 | (32'(p / 8) << 8) | 32'(r * 16 + p % 8);
    endfunction

    always_comb begin
        for (int r = 0; r < ROWS; r++) begin
            fifo_empty[r] = force_empty[r] || (rptr[r] >= avail[r]);
            fifo_rd_data[r*DW +: DW] = rd_q[r];
        end
    end

    always @(posedge clk) begin
        for (int r = 0; r < ROWS; r++) begin
            if (fifo_rd_en[r]) begin
                if (fifo_empty[r]) uflow <= uflow + 1;
                rd_q[r] <= word(r, rptr[r]);
                rptr[r] <= rptr[r] + 1;
            end
        end
        if (fifo_rd_en1[0]) rd_q1 <= 32'h0000_0055;
    end

    assign fifo_rd_data1 = rd_q1;
    assign fifo_empty1   = 1'b0;

    typedef struct {
        int         k;
        logic       busy;
        logic       done;
        logic [3:0] rd_en;
        logic [3:0] valid;
    } vec_t;

    localparam int NT = 10;
    vec_t tab[NT];

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic load();
        for (int r = 0; r < ROWS; r++) begin
            for (int i = 0; i < K; i++) sb[r].push_back(word(r, avail[r] + i));
            avail[r] = avail[r] + K;
        end
    endtask

    task automatic run_op(input bit use_tab, input int st_at,
                          input int st_len, input bit spam);
        int ncyc;
        int busy_n;
        int done_n;
        int rd_n [ROWS];
        int first[ROWS];
        int efirst;
        ncyc   = K + ROWS + st_len;
        busy_n = 0;
        done_n = 0;
        for (int r = 0; r < ROWS; r++) begin
            rd_n[r]  = 0;
            first[r] = -1;
        end
        load();
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        for (int k = 0; k < ncyc + 3; k++) begin
            force_empty = (k >= st_at && k < st_at + st_len) ? 4'b0100 : 4'b0000;
            start = spam && (k <= ncyc);
            #1;
            if (busy) busy_n++;
            if (done) done_n++;
            for (int r = 0; r < ROWS; r++) begin
                if (fifo_rd_en[r]) rd_n[r]++;
                if (a_valid[r]) begin
                    if (first[r] < 0) first[r] = k;
                    if (sb[r].size() == 0) begin
                        chk($sformatf("extra word r%0d", r), 32'd1, 32'd0);
                    end else begin
                        chk($sformatf("data r%0d k%0d", r, k),
                            a_data[r*DW +: DW], sb[r].pop_front());
                    end
                end else begin
                    chk($sformatf("zero pad r%0d k%0d", r, k),
                        a_data[r*DW +: DW], 32'd0);
                end
            end
            if (use_tab) begin
                for (int i = 0; i < NT; i++) begin
                    if (tab[i].k == k) begin
                        chk($sformatf("busy k%0d", k), 32'(busy), 32'(tab[i].busy));
                        chk($sformatf("done k%0d", k), 32'(done), 32'(tab[i].done));
                        chk($sformatf("rd_en k%0d", k), 32'(fifo_rd_en), 32'(tab[i].rd_en));
                        chk($sformatf("valid k%0d", k), 32'(a_valid), 32'(tab[i].valid));
                    end
                end
            end
            if (k >= st_at && k < st_at + st_len)
                chk($sformatf("stall rd_en k%0d", k), 32'(fifo_rd_en), 32'd0);
            if (k > st_at && k <= st_at + st_len)
                chk($sformatf("stall valid k%0d", k), 32'(a_valid), 32'd0);
            @(posedge clk); #1;
        end
        start       = 1'b0;
        force_empty = '0;
        chk("busy cycles", 32'(busy_n), 32'(ncyc));
        chk("done pulses", 32'(done_n), 32'd1);
        for (int r = 0; r < ROWS; r++) begin
            efirst = r + 1 + ((st_len > 0 && r >= st_at) ? st_len : 0);
            chk($sformatf("reads r%0d", r), 32'(rd_n[r]), 32'(K));
            chk($sformatf("first valid r%0d", r), 32'(first[r]), 32'(efirst));
            chk($sformatf("sb left r%0d", r), 32'(sb[r].size()), 32'd0);
        end
    endtask

    initial begin
        int bad;
        tab[0] = '{k: 0,  busy: 1, done: 0, rd_en: 4'b0001, valid: 4'b0000};
        tab[1] = '{k: 1,  busy: 1, done: 0, rd_en: 4'b0011, valid: 4'b0001};
        tab[2] = '{k: 3,  busy: 1, done: 0, rd_en: 4'b1111, valid: 4'b0111};
        tab[3] = '{k: 7,  busy: 1, done: 0, rd_en: 4'b1111, valid: 4'b1111};
        tab[4] = '{k: 8,  busy: 1, done: 0, rd_en: 4'b1110, valid: 4'b1111};
        tab[5] = '{k: 9,  busy: 1, done: 0, rd_en: 4'b1100, valid: 4'b1110};
        tab[6] = '{k: 10, busy: 1, done: 0, rd_en: 4'b1000, valid: 4'b1100};
        tab[7] = '{k: 11, busy: 1, done: 0, rd_en: 4'b0000, valid: 4'b1000};
        tab[8] = '{k: 12, busy: 0, done: 1, rd_en: 4'b0000, valid: 4'b0000};
        tab[9] = '{k: 13, busy: 0, done: 0, rd_en: 4'b0000, valid: 4'b0000};

        rst_n  = 1'b0;
        start  = 1'b0;
        start1 = 1'b0;
        #2;
        chk("reset busy", 32'(busy), 32'd0);
        chk("reset done", 32'(done), 32'd0);
        chk("reset valid", 32'(a_valid), 32'd0);
        chk("reset rd_en", 32'(fifo_rd_en), 32'd0);
        chk("reset a_data", a_data[31:0] | a_data[63:32] | a_data[95:64] | a_data[127:96], 32'd0);
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        load();
        bad = 0;
        repeat (5) begin
            @(posedge clk); #1;
            if (fifo_rd_en != 0 || busy) bad++;
        end
        chk("no read before start", 32'(bad), 32'd0);
        for (int r = 0; r < ROWS; r++) sb[r].delete();
        for (int r = 0; r < ROWS; r++) avail[r] = rptr[r];

        run_op(1'b1, 99, 0, 1'b0);
        run_op(1'b0, 2, 3, 1'b0);
        run_op(1'b0, 99, 0, 1'b1);

        load();
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        chk("pre-reset rd_en", 32'(fifo_rd_en), 32'hF);
        rst_n = 1'b0;
        #1;
        chk("mid reset rd_en", 32'(fifo_rd_en), 32'd0);
        chk("mid reset valid", 32'(a_valid), 32'd0);
        chk("mid reset busy", 32'(busy), 32'd0);
        chk("mid reset done", 32'(done), 32'd0);
        chk("mid reset a_data", a_data[31:0] | a_data[63:32] | a_data[95:64] | a_data[127:96], 32'd0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        bad = 0;
        repeat (6) begin
            @(posedge clk); #1;
            if (fifo_rd_en != 0 || busy || a_valid != 0) bad++;
        end
        chk("idle after reset", 32'(bad), 32'd0);
        for (int r = 0; r < ROWS; r++) begin
            sb[r].delete();
            avail[r] = rptr[r];
        end
        run_op(1'b1, 99, 0, 1'b0);

        sb1.push_back(32'h0000_0055);
        #1;
        chk("k1 idle pad", a_data1, 32'd0);
        start1 = 1'b1;
        @(posedge clk); #1;
        start1 = 1'b0;
        chk("k1 rd_en c0", 32'(fifo_rd_en1), 32'd1);
        chk("k1 busy c0", 32'(busy1), 32'd1);
        chk("k1 valid c0", 32'(a_valid1), 32'd0);
        @(posedge clk); #1;
        chk("k1 rd_en c1", 32'(fifo_rd_en1), 32'd0);
        chk("k1 valid c1", 32'(a_valid1), 32'd1);
        chk("k1 busy c1", 32'(busy1), 32'd1);
        if (a_valid1[0] && sb1.size() > 0)
            chk("k1 data", a_data1, sb1.pop_front());
        else
            chk("k1 data present", 32'(sb1.size()), 32'd99);
        @(posedge clk); #1;
        chk("k1 done c2", 32'(done1), 32'd1);
        chk("k1 busy c2", 32'(busy1), 32'd0);
        chk("k1 pad c2", a_data1, 32'd0);
        @(posedge clk); #1;
        chk("k1 done c3", 32'(done1), 32'd0);

        chk("fifo underflow", 32'(uflow), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
